// File: rtl/fifo_pkg.sv
// Shared definitions for FIFO controllers: read-scheduler state encoding and an index-width helper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fifo_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } rd_state_e;

    // Width of an index able to address n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order output buffer with a registered head (out_vld/out_dat come straight from flops).
// Latency: a word pushed in cycle t is presented from cycle t+1.
// Backpressure: head holds stable while out_vld && !out_rdy; the producer must not push into a full buffer.
module fifo_rd_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy,
    output logic [1:0]   count
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         head_vld_q;
    logic         tail_vld_q;
    logic         pop;

    assign pop     = head_vld_q && out_rdy;
    assign out_vld = head_vld_q;
    assign out_dat = head_q;
    assign count   = {1'b0, head_vld_q} + {1'b0, tail_vld_q};

    // Head/tail update: the tail only ever refills the head, so ordering is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else if (!head_vld_q) begin
            if (push_vld) begin
                head_q     <= push_dat;
                head_vld_q <= 1'b1;
            end
        end else if (!tail_vld_q) begin
            if (pop && push_vld) begin
                head_q <= push_dat;
            end else if (pop) begin
                head_vld_q <= 1'b0;
            end else if (push_vld) begin
                tail_q     <= push_dat;
                tail_vld_q <= 1'b1;
            end
        end else if (pop) begin
            head_q <= tail_q;
            if (push_vld) begin
                tail_q <= push_dat;
            end else begin
                tail_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_sched.sv
// Round-robin burst scheduler draining NUM_SRC registered-read FIFOs into one tagged valid/ready stream.
// Latency: o_rd_en in cycle t -> word in the output buffer at end of t+1 -> o_valid from t+2.
// Backpressure: reads are credit-limited to the 2-entry buffer, so i_ready low stops reads with no overflow.
module fifo_rd_sched
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_SRC    = 4,
    parameter  int BURST_LEN  = 2,
    localparam int SRC_W      = idx_width(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            i_empty,
    output logic [NUM_SRC-1:0]            o_rd_en,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_rd_data,
    output logic                          o_valid,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic [SRC_W-1:0]              o_src,
    input  logic                          i_ready,
    output logic                          o_busy
);

    localparam int                CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [SRC_W-1:0]  LAST_SRC  = SRC_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    rd_state_e              state_q, state_d;
    logic [SRC_W-1:0]       owner_q, owner_d;
    logic [CNT_W-1:0]       burst_q, burst_d;
    logic                   inflight_q;
    logic [NUM_SRC-1:0]     rd_en;
    logic [1:0]             buf_count;
    logic [1:0]             credit_sum;
    logic                   pop;
    logic                   credit_ok;
    logic                   pick_ok;
    logic [SRC_W-1:0]       pick;
    logic [SRC_W+DATA_WIDTH-1:0] push_dat;
    logic [SRC_W+DATA_WIDTH-1:0] head_dat;

    // First requester after 'last' in cyclic order; 'last' itself is considered at the very end.
    function automatic logic [SRC_W:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [SRC_W-1:0]   last);
        logic             found;
        logic [SRC_W-1:0] idx;
        int               c;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            c = (int'(last) + i) % NUM_SRC;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = SRC_W'(c);
            end
        end
        return {found, idx};
    endfunction

    // Buffer occupancy plus the in-flight read never exceeds 2, so the 2-bit sum cannot wrap.
    assign pop             = o_valid && i_ready;
    assign credit_sum      = buf_count + {1'b0, inflight_q};
    assign credit_ok       = (credit_sum - {1'b0, pop}) < 2'd2;
    assign {pick_ok, pick} = rr_pick(~i_empty, owner_q);

    // Next-state, owner/burst update and read-enable selection.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        burst_d = burst_q;
        rd_en   = '0;
        if (credit_ok) begin
            if (state_q == ST_LOCKED && !i_empty[owner_q] && burst_q < BURST_MAX) begin
                rd_en[owner_q] = 1'b1;
                burst_d        = burst_q + CNT_ONE;
            end else if (pick_ok) begin
                rd_en[pick] = 1'b1;
                owner_d     = pick;
                burst_d     = CNT_ONE;
                state_d     = ST_LOCKED;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Read enables are forced low while reset is held so no FIFO is popped during reset.
    assign o_rd_en = rst_n ? rd_en : '0;

    // Scheduler state; owner only moves when a read is issued, so it also names the in-flight source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= LAST_SRC;
            burst_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            burst_q    <= burst_d;
            inflight_q <= |rd_en;
        end
    end

    assign push_dat = {owner_q, i_rd_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH]};

    fifo_rd_skid #(
        .W (SRC_W + DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (inflight_q),
        .push_dat (push_dat),
        .out_vld  (o_valid),
        .out_dat  (head_dat),
        .out_rdy  (i_ready),
        .count    (buf_count)
    );

    assign o_data = head_dat[DATA_WIDTH-1:0];
    assign o_src  = head_dat[DATA_WIDTH +: SRC_W];
    assign o_busy = inflight_q || (buf_count != 2'd0);

endmodule

// File: tb/tb_fifo_rd_sched.sv
module tb_fifo_rd_sched;

    localparam int DW = 8;
    localparam int NS = 4;
    localparam int BL = 2;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NS-1:0]    i_empty;
    logic [NS-1:0]    o_rd_en;
    logic [NS*DW-1:0] i_rd_data;
    logic             o_valid;
    logic [DW-1:0]    o_data;
    logic [SW-1:0]    o_src;
    logic             i_ready;
    logic             o_busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0]    fq [NS][$];
    logic [DW-1:0]    rq [NS][$];
    logic [SW+DW-1:0] got[$];
    logic [SW+DW-1:0] exp_q[$];
    logic             hold_prev = 1'b0;
    logic [SW+DW-1:0] hold_dat = '0;
    logic [3:0]       trd [6];
    logic             tv  [6];

    always #5 clk = ~clk;

    fifo_rd_sched #(
        .DATA_WIDTH (DW),
        .NUM_SRC    (NS),
        .BURST_LEN  (BL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_empty   (i_empty),
        .o_rd_en   (o_rd_en),
        .i_rd_data (i_rd_data),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_src     (o_src),
        .i_ready   (i_ready),
        .o_busy    (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registered-read FIFO models: data one cycle after rd_en, empty flag updates after the pop.
    always @(posedge clk) begin
        for (int k = 0; k < NS; k++) begin
            if (o_rd_en[k]) begin
                i_rd_data[k*DW +: DW] <= fq[k].pop_front();
                i_empty[k]            <= (fq[k].size() == 0);
            end
        end
    end

    // Output monitor and per-cycle invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rd_onehot", 32'($countones(o_rd_en) <= 1), 32'd1);
            check("rd_while_empty", 32'(o_rd_en & i_empty), 32'd0);
            if (hold_prev) check("hold_stable", 32'({o_valid, o_src, o_data}), 32'({1'b1, hold_dat}));
            if (o_valid && i_ready) got.push_back({o_src, o_data});
            hold_prev = o_valid && !i_ready;
            hold_dat  = {o_src, o_data};
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [DW-1:0] d);
        fq[k].push_back(d);
        rq[k].push_back(d);
        i_empty[k] <= 1'b0;
    endtask

    task automatic resync();
        for (int k = 0; k < NS; k++) rq[k] = fq[k];
    endtask

    // Reference order: visit sources cyclically after the start owner, taking up to BL words each.
    function automatic void ref_order(input int start);
        int o;
        int left;
        o = start;
        left = 0;
        exp_q.delete();
        for (int k = 0; k < NS; k++) left += rq[k].size();
        while (left > 0) begin
            o = (o + 1) % NS;
            for (int j = 0; j < BL && rq[o].size() > 0; j++) begin
                exp_q.push_back({SW'(o), rq[o].pop_front()});
                left--;
            end
        end
    endfunction

    task automatic cmp_stream(input string tag);
        check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check({tag, "_word"}, 32'(got[i]), 32'(exp_q[i]));
    endtask

    task automatic drain(input string tag, input int n, input int budget, input bit rnd);
        int c;
        c = 0;
        while (got.size() < n && c < budget) begin
            nxt();
            i_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            smp();
            c++;
        end
        repeat (3) begin
            nxt();
            i_ready = 1'b1;
            smp();
        end
        cmp_stream(tag);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 6; i++) begin
            smp();
            check({tag, "_rd_en"}, 32'(o_rd_en), 32'(trd[i]));
            check({tag, "_valid"}, 32'(o_valid), 32'(tv[i]));
            nxt();
        end
    endtask

    initial begin
        int c;
        int n_rd;
        int total;
        int cnt;
        i_ready = 1'b0;
        i_empty <= '1;
        i_rd_data <= '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_rd_en", 32'(o_rd_en), 32'd0);
        check("rst_src", 32'(o_src), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        rst_n = 1'b1;
        nxt();

        // Single source back-to-back with the 2-cycle read-to-valid latency.
        got.delete();
        load(2, 8'hA0); load(2, 8'hA1); load(2, 8'hA2);
        i_ready = 1'b1;
        ref_order(3);
        trd = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        tv  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        run_table("single");
        cmp_stream("single");
        check("single_busy", 32'(o_busy), 32'd0);

        // Asynchronous reset mid-cycle while words are buffered and a FIFO is still non-empty.
        got.delete();
        load(3, 8'hE0); load(3, 8'hE1); load(3, 8'hE2);
        i_ready = 1'b0;
        repeat (4) nxt();
        check("pre_rst_valid", 32'(o_valid), 32'd1);
        check("pre_rst_src", 32'(o_src), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(o_valid), 32'd0);
        check("async_rd_en", 32'(o_rd_en), 32'd0);
        check("async_src", 32'(o_src), 32'd0);
        check("async_data", 32'(o_data), 32'd0);
        check("async_busy", 32'(o_busy), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resync();
        got.delete();
        ref_order(3);
        drain("after_rst", 1, 30, 1'b0);

        // All four sources loaded: bursts of two, full throughput.
        nxt();
        got.delete();
        for (int k = 0; k < NS; k++)
            for (int j = 0; j < 4; j++) load(k, 8'(k * 16 + j));
        i_ready = 1'b1;
        ref_order(3);
        c = 0;
        while (c < 60) begin
            smp();
            if (got.size() >= 16) break;
            c++;
            nxt();
        end
        check("rr_cycles", 32'(c), 32'd17);
        nxt();
        smp();
        cmp_stream("rr");
        check("rr_busy", 32'(o_busy), 32'd0);

        // Move owner to source 0, then rotate past an emptied owner without a bubble.
        nxt();
        got.delete();
        load(0, 8'h55);
        ref_order(3);
        drain("own0", 1, 30, 1'b0);
        nxt();
        got.delete();
        load(1, 8'h1A); load(3, 8'h3A); load(3, 8'h3B);
        ref_order(0);
        trd = '{4'b0010, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        tv  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        run_table("rotate");
        cmp_stream("rotate");
        check("rotate_busy", 32'(o_busy), 32'd0);

        // Backpressure: only two reads fit the buffer credit, head held stable.
        got.delete();
        i_ready = 1'b0;
        for (int j = 0; j < 5; j++) load(0, 8'(j));
        ref_order(3);
        n_rd = 0;
        repeat (8) begin
            smp();
            if (o_rd_en != '0) n_rd++;
            nxt();
        end
        check("bp_reads", 32'(n_rd), 32'd2);
        check("bp_rd_en", 32'(o_rd_en), 32'd0);
        check("bp_valid", 32'(o_valid), 32'd1);
        check("bp_head", 32'({o_src, o_data}), 32'h000);
        drain("bp", 5, 60, 1'b0);

        // Reset the cycle after a read from source 2: that word is lost, owner restarts at 3.
        nxt();
        got.delete();
        i_ready = 1'b1;
        load(2, 8'hC0); load(2, 8'hC1); load(0, 8'hD0);
        smp();
        check("drop_rd_en", 32'(o_rd_en), 32'b0100);
        nxt();
        rst_n = 1'b0;
        #1;
        check("drop_valid", 32'(o_valid), 32'd0);
        check("drop_busy", 32'(o_busy), 32'd0);
        check("drop_rd_en_rst", 32'(o_rd_en), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resync();
        ref_order(3);
        smp();
        check("drop_first_grant", 32'(o_rd_en), 32'b0001);
        drain("drop", 2, 30, 1'b0);

        // Randomised contents and random downstream stalls against the reference order.
        for (int r = 0; r < 6; r++) begin
            nxt();
            rst_n = 1'b0;
            nxt();
            rst_n = 1'b1;
            got.delete();
            total = 0;
            for (int k = 0; k < NS; k++) begin
                cnt = $urandom_range(0, 6);
                for (int j = 0; j < cnt; j++) load(k, 8'($urandom));
                total += cnt;
            end
            ref_order(3);
            drain("rand", total, 400, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_sched.md
Name: fifo_rd_sched

Overview:
Read-side scheduler that drains NUM_SRC independent `fifo` instances into one valid/ready stream.
- Picks a non-empty FIFO by round-robin with a configurable burst length.
- Drives that FIFO's read enable and absorbs the FIFO's 1-cycle registered read latency.
- Tags each output word with its source index.
- Sits between per-channel FIFOs and a single shared downstream consumer (e.g. a UART TX or bus master).

Parameters:
- DATA_WIDTH, 8: width of each FIFO word.
- NUM_SRC, 4: number of FIFOs served (>=2).
- BURST_LEN, 2: max consecutive reads granted to one source before rotation (>=1).
- SRC_W, $clog2(NUM_SRC): width of the source tag (localparam).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- i_empty  input  NUM_SRC  o_empty of each FIFO.
- o_rd_en  output  NUM_SRC  i_rd_en to each FIFO; at most one bit high per cycle.
- i_rd_data  input  NUM_SRC*DATA_WIDTH  concatenated o_rd_data of all FIFOs; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_valid  output  1  output word valid.
- o_data  output  DATA_WIDTH  output word.
- o_src  output  SRC_W  index of the FIFO that supplied o_data.
- i_ready  input  1  downstream accepts; a transfer occurs when o_valid && i_ready.
- o_busy  output  1  a read is in flight or the output buffer is non-empty.

Behaviour:
- Reset (async, rst_n low), all registered:
  - o_rd_en=0, o_valid=0, o_data=0, o_src=0, o_busy=0.
  - owner=NUM_SRC-1, burst_cnt=0, inflight=0, state=IDLE.
  - Output buffer emptied; any in-flight read is discarded.
- Read latency:
  - o_rd_en[k] high in cycle t means FIFO k's data is valid on i_rd_data[k] in cycle t+1.
  - That word is written into the 2-entry output buffer at the end of t+1.
  - o_valid is high in t+2 at the earliest.
- Credit rule:
  - A read may be issued in cycle t only if (buf_count + inflight - pop_t) < 2.
  - pop_t = o_valid && i_ready in cycle t.
  - This guarantees no overflow and sustains 1 word/cycle while i_ready=1.
- Never assert o_rd_en[k] while i_empty[k]=1.
  - The FIFO's empty flag updates the cycle after a read, so back-to-back reads of a 1-entry FIFO cannot occur.
- State machine, owner register, burst_cnt:
  - IDLE: no read issued.
    - If the credit rule allows and any FIFO is non-empty, grant the first non-empty index after owner (cyclic) and issue a read.
    - Set owner to that index, burst_cnt=1, go to LOCKED.
  - LOCKED, keep owner: if credit allows, !i_empty[owner] and burst_cnt<BURST_LEN, issue a read from owner and increment burst_cnt.
  - LOCKED, rotate: if credit allows and (i_empty[owner] or burst_cnt==BURST_LEN), re-arbitrate in the same cycle with no bubble.
    - The search starts at owner+1 and wraps modulo NUM_SRC.
    - owner is eligible again last, only if it is the sole non-empty source; this restarts the burst with burst_cnt=1.
  - LOCKED, no candidate: if no FIFO is eligible, go to IDLE.
  - LOCKED, no credit: if credit is blocked, hold owner and burst_cnt unchanged and issue nothing.
- Output buffer:
  - In-order; o_data, o_src and o_valid come directly from registers.
  - o_data and o_src stay stable while o_valid && !i_ready.
- Widths:
  - burst_cnt is $clog2(BURST_LEN+1) bits.
  - inflight is 1 bit; the credit sum is computed in 2 bits with no wrap.
- o_busy = inflight || buf_count!=0.

Decomposition:
- Shared package/header `fifo_pkg`: the clog2-based SRC_W helper and the IDLE/LOCKED state encodings, reused by future FIFO controllers.
- One sub-module, `fifo_rd_skid`: the 2-entry output buffer with push/pop, count and registered head.
- The round-robin pick stays in this block as a combinational priority-rotate function.

Test Plan (NUM_SRC=4, DATA_WIDTH=8, BURST_LEN=2):
1. Assert rst_n=0 mid-simulation -> o_valid=0, o_rd_en=4'b0000, o_src=0, o_busy=0 immediately, without waiting for clk.
2. Only FIFO2 holds 8'hA0, 8'hA1, 8'hA2; i_ready=1 -> o_rd_en=4'b0100 for 3 consecutive cycles; outputs A0, A1, A2 with o_src=2 back-to-back; first o_valid 2 cycles after the first o_rd_en.
3. All FIFOs hold 4 words (8'h{k}0..8'h{k}3); i_ready=1 -> o_src sequence 0,0,1,1,2,2,3,3,0,0,...
   - Each source's data arrives in order; 16 words in 16 consecutive cycles after a 2-cycle startup.
4. FIFO1 holds 1 word, FIFO3 holds 2, owner=0 -> read FIFO1 once, rotate without a bubble, read FIFO3 twice, then IDLE.
   - o_src sequence 1,3,3.
5. i_ready=0 with FIFO0 holding 5 words -> exactly 2 reads issued, then o_rd_en=0.
   - o_data=8'h00 (first word) held stable.
   - On i_ready=1, all 5 words delivered once each, in order.
6. rst_n pulsed low the cycle after o_rd_en[2]=1 -> that word is dropped, o_valid=0.
   - After release, the first grant goes to FIFO0 (owner reset to 3).
